// File: rtl/serial_pkg.sv
// Shared definitions for the serial adder front end: feeder FSM states, default operand width, FIFO entry sizing.
package serial_pkg;

   localparam int SER_WIDTH = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } feeder_state_t;

   // Each FIFO entry holds {cin, b, a}.
   function automatic int entry_width(input int width);
      return 2 * width + 1;
   endfunction

endpackage

// File: rtl/serial_feeder_fifo.sv
// Synchronous FIFO, read data combinational from head; 1-cycle push-to-visible latency.
// Push ignored when full, pop ignored when empty; simultaneous push/pop keeps the count.
module serial_feeder_fifo #(
   parameter int DEPTH = 2,
   parameter int DW    = 9
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_push,
   input  logic [DW-1:0] i_push_dat,
   input  logic          i_pop,
   output logic [DW-1:0] o_pop_dat,
   output logic          o_full,
   output logic          o_empty
);
   localparam int AW = $clog2(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];
   logic [AW:0]   r_wr_ptr;
   logic [AW:0]   r_rd_ptr;
   logic          w_wr;
   logic          w_rd;

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign o_empty   = (r_wr_ptr == r_rd_ptr);
   assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign w_wr      = i_push && !o_full;
   assign w_rd      = i_pop && !o_empty;
   assign o_pop_dat = r_mem[r_rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
   end

endmodule

// File: rtl/serial_operand_feeder.sv
// Buffers operand pairs and streams them LSB-first with first/last framing and GAP idle cycles between words;
// bit 0 appears one edge after the push edge, ser_en=0 freezes the serial side. `SERIAL_FEEDER_STATS_EN adds word_count.
module serial_operand_feeder
   import serial_pkg::*;
#(
   parameter int WIDTH = SER_WIDTH,
   parameter int DEPTH = 2,
   parameter int GAP   = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             ser_en,
   output logic             ser_valid,
   output logic             ser_a,
   output logic             ser_b,
   output logic             ser_cin,
   output logic             ser_first,
   output logic             ser_last
`ifdef SERIAL_FEEDER_STATS_EN
   ,
   output logic [15:0]      word_count
`endif
);
   localparam int EW = entry_width(WIDTH);
   localparam int BW = $clog2(WIDTH);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

   logic          w_full;
   logic          w_empty;
   logic          w_pop;
   logic          w_at_last;
   logic          w_gap_done;
   logic [EW-1:0] w_head;

   feeder_state_t    r_state;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [BW-1:0]    r_bit_cnt;
   logic [GW-1:0]    r_gap_cnt;
   logic             r_valid;
   logic             r_cin;
   logic             r_first;
   logic             r_last;

   serial_feeder_fifo #(
      .DEPTH (DEPTH),
      .DW    (EW)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (in_valid),
      .i_push_dat ({in_cin, in_b, in_a}),
      .i_pop      (w_pop),
      .o_pop_dat  (w_head),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   assign in_ready   = !w_full;
   assign w_at_last  = (r_state == ST_SHIFT) && (r_bit_cnt == BIT_LAST);
   assign w_gap_done = (r_state == ST_GAP) && (r_gap_cnt == GAP_LAST);
   // Every word boundary that may pull the next pair straight into the shifter.
   assign w_pop = ser_en && !w_empty &&
                  ((r_state == ST_IDLE) || w_gap_done || (w_at_last && (GAP == 0)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_sa      <= '0;
         r_sb      <= '0;
         r_bit_cnt <= '0;
         r_gap_cnt <= '0;
         r_valid   <= 1'b0;
         r_cin     <= 1'b0;
         r_first   <= 1'b0;
         r_last    <= 1'b0;
      end else if (ser_en) begin
         if (w_pop) begin
            r_state   <= ST_SHIFT;
            r_sa      <= w_head[WIDTH-1:0];
            r_sb      <= w_head[2*WIDTH-1:WIDTH];
            r_cin     <= w_head[2*WIDTH];
            r_bit_cnt <= '0;
            r_valid   <= 1'b1;
            r_first   <= 1'b1;
            r_last    <= 1'b0;
         end else begin
            case (r_state)
               ST_SHIFT: begin
                  if (w_at_last) begin
                     r_state   <= (GAP != 0) ? ST_GAP : ST_IDLE;
                     r_gap_cnt <= '0;
                     r_sa      <= '0;
                     r_sb      <= '0;
                     r_valid   <= 1'b0;
                     r_cin     <= 1'b0;
                     r_first   <= 1'b0;
                     r_last    <= 1'b0;
                  end else begin
                     r_sa      <= r_sa >> 1;
                     r_sb      <= r_sb >> 1;
                     r_bit_cnt <= r_bit_cnt + 1'b1;
                     r_cin     <= 1'b0;
                     r_first   <= 1'b0;
                     r_last    <= ((r_bit_cnt + 1'b1) == BIT_LAST);
                  end
               end
               ST_GAP: begin
                  if (w_gap_done) r_state <= ST_IDLE;
                  else            r_gap_cnt <= r_gap_cnt + 1'b1;
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign ser_valid = r_valid;
   assign ser_a     = r_sa[0];
   assign ser_b     = r_sb[0];
   assign ser_cin   = r_cin;
   assign ser_first = r_first;
   assign ser_last  = r_last;

`ifdef SERIAL_FEEDER_STATS_EN
   logic [15:0] r_word_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                r_word_count <= '0;
      else if (ser_en && r_last) r_word_count <= r_word_count + 16'd1;
   end

   assign word_count = r_word_count;
`endif

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Bench for serial_operand_feeder: directed timelines plus a randomized run against a bit-queue reference model.
module tb_serial_operand_feeder;
   localparam int W     = 4;
   localparam int DEPTH = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst;
   logic         in_valid, in_cin, ser_en;
   logic [W-1:0] in_a, in_b;
   logic         in_ready, ser_valid, ser_a, ser_b, ser_cin, ser_first, ser_last;
   logic         g_in_valid, g_in_cin, g_ser_en;
   logic [W-1:0] g_in_a, g_in_b;
   logic         g_in_ready, g_ser_valid, g_ser_a, g_ser_b, g_ser_cin, g_ser_first, g_ser_last;
   logic [5:0]   obs, g_obs;
`ifdef SERIAL_FEEDER_STATS_EN
   logic [15:0]  word_count, g_word_count;
`endif

   int total = 0;
   int bad   = 0;

   assign obs   = {ser_valid, ser_a, ser_b, ser_cin, ser_first, ser_last};
   assign g_obs = {g_ser_valid, g_ser_a, g_ser_b, g_ser_cin, g_ser_first, g_ser_last};

   serial_operand_feeder #(.WIDTH(W), .DEPTH(DEPTH), .GAP(1)) u_dut (
`ifdef SERIAL_FEEDER_STATS_EN
      .word_count (word_count),
`endif
      .clk (clk), .rst (rst),
      .in_valid (in_valid), .in_ready (in_ready), .in_a (in_a), .in_b (in_b), .in_cin (in_cin),
      .ser_en (ser_en), .ser_valid (ser_valid), .ser_a (ser_a), .ser_b (ser_b),
      .ser_cin (ser_cin), .ser_first (ser_first), .ser_last (ser_last)
   );

   serial_operand_feeder #(.WIDTH(W), .DEPTH(DEPTH), .GAP(0)) u_dut_g (
`ifdef SERIAL_FEEDER_STATS_EN
      .word_count (g_word_count),
`endif
      .clk (clk), .rst (rst),
      .in_valid (g_in_valid), .in_ready (g_in_ready), .in_a (g_in_a), .in_b (g_in_b), .in_cin (g_in_cin),
      .ser_en (g_ser_en), .ser_valid (g_ser_valid), .ser_a (g_ser_a), .ser_b (g_ser_b),
      .ser_cin (g_ser_cin), .ser_first (g_ser_first), .ser_last (g_ser_last)
   );

   // Expected {valid, a, b, cin, first, last} while bit i of a word is on the wire.
   function automatic logic [5:0] exp_bit(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic cin, input int i);
      return {1'b1, a[i], b[i], (i == 0) ? cin : 1'b0, (i == 0), (i == W - 1)};
   endfunction

   task automatic test_reset;
      rst = 1'b0;
      in_valid = 0; in_a = '0; in_b = '0; in_cin = 0; ser_en = 0;
      g_in_valid = 0; g_in_a = '0; g_in_b = '0; g_in_cin = 0; g_ser_en = 0;
      repeat (3) @(negedge clk);
      total++; if ({obs, in_ready} !== 7'b0000001) begin bad++; $display("FAIL reset_outputs got=%b want=%b", {obs, in_ready}, 7'b0000001); end
      total++; if ({g_obs, g_in_ready} !== 7'b0000001) begin bad++; $display("FAIL reset_outputs_g got=%b want=%b", {g_obs, g_in_ready}, 7'b0000001); end
      rst = 1'b1;
      @(negedge clk);
      total++; if ({obs, in_ready} !== 7'b0000001) begin bad++; $display("FAIL post_reset_idle got=%b want=%b", {obs, in_ready}, 7'b0000001); end
   endtask

   task automatic test_single_word;
      logic [W-1:0] a0 = 4'b1011, b0 = 4'b0110, a1 = 4'b0100, b1 = 4'b1001;
      logic [5:0]   exp;
      ser_en = 1; in_valid = 1; in_a = a0; in_b = b0; in_cin = 1;
      @(negedge clk);
      total++; if (obs !== 6'b0) begin bad++; $display("FAIL single_latency got=%b want=%b", obs, 6'b0); end
      in_a = a1; in_b = b1; in_cin = 0;
      @(negedge clk);
      in_valid = 0;
      for (int k = 0; k < 10; k++) begin
         if (k < 4)                exp = exp_bit(a0, b0, 1'b1, k);
         else if (k == 4 || k == 9) exp = 6'b0;
         else                       exp = exp_bit(a1, b1, 1'b0, k - 5);
         total++; if (obs !== exp) begin bad++; $display("FAIL single_seq k=%0d got=%b want=%b", k, obs, exp); end
         @(negedge clk);
      end
   endtask

   task automatic test_back_to_back;
      logic [W-1:0] a0, b0, a1, b1;
      logic         c0, c1;
      logic [5:0]   exp;
      a0 = W'($urandom); b0 = W'($urandom); c0 = 1'($urandom);
      a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
      g_ser_en = 1; g_in_valid = 1; g_in_a = a0; g_in_b = b0; g_in_cin = c0;
      @(negedge clk);
      total++; if (g_obs !== 6'b0) begin bad++; $display("FAIL b2b_latency got=%b want=%b", g_obs, 6'b0); end
      g_in_a = a1; g_in_b = b1; g_in_cin = c1;
      @(negedge clk);
      g_in_valid = 0;
      for (int k = 0; k < 9; k++) begin
         if (k < 4)      exp = exp_bit(a0, b0, c0, k);
         else if (k < 8) exp = exp_bit(a1, b1, c1, k - 4);
         else            exp = 6'b0;
         total++; if (g_obs !== exp) begin bad++; $display("FAIL b2b_seq k=%0d got=%b want=%b", k, g_obs, exp); end
         @(negedge clk);
      end
   endtask

   task automatic test_backpressure;
      logic [2*W:0] wd [3];
      logic [2*W:0] got [3];
      logic [W-1:0] ga, gb;
      logic         gc;
      int           idx, nwords;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) wd[i] = (2*W+1)'($urandom);
      ga = '0; gb = '0; gc = 0; idx = 0; nwords = 0;
      ser_en = 0; in_valid = 1; {in_cin, in_b, in_a} = wd[0];
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c0 got=%b want=1", in_ready); end
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_c1 got=%b want=1", in_ready); end
      {in_cin, in_b, in_a} = wd[1];
      @(negedge clk);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b want=0", in_ready); end
      {in_cin, in_b, in_a} = wd[2];
      @(negedge clk);
      total++; if ({in_ready, ser_valid} !== 2'b00) begin bad++; $display("FAIL bp_held_off got=%b want=00", {in_ready, ser_valid}); end
      ser_en = 1;
      @(negedge clk);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_after_pop got=%b want=1", in_ready); end
      for (int n = 0; n < 40 && nwords < 3; n++) begin
         if (ser_valid) begin
            if (ser_first) begin ga = '0; gb = '0; gc = ser_cin; idx = 0; end
            if (idx < W) begin ga[idx] = ser_a; gb[idx] = ser_b; end
            idx++;
            if (ser_last) begin got[nwords] = {gc, gb, ga}; nwords++; end
         end
         if (n > 0) in_valid = 0;
         @(negedge clk);
      end
      in_valid = 0;
      total++; if (nwords !== 3) begin bad++; $display("FAIL bp_word_count got=%0d want=3", nwords); end
      for (int i = 0; i < nwords; i++) begin
         total++; if (got[i] !== wd[i]) begin bad++; $display("FAIL bp_order i=%0d got=%h want=%h", i, got[i], wd[i]); end
      end
   endtask

   task automatic test_freeze;
      logic [W-1:0] a, b;
      logic         c;
      logic [5:0]   exp;
      int           bi [8] = '{0, 1, 2, 2, 2, 2, 3, -1};
      repeat (3) @(negedge clk);
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      ser_en = 1; in_valid = 1; in_a = a; in_b = b; in_cin = c;
      @(negedge clk);
      in_valid = 0;
      total++; if (obs !== 6'b0) begin bad++; $display("FAIL freeze_latency got=%b want=%b", obs, 6'b0); end
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         exp = (bi[k] < 0) ? 6'b0 : exp_bit(a, b, c, bi[k]);
         total++; if (obs !== exp) begin bad++; $display("FAIL freeze_seq k=%0d got=%b want=%b", k, obs, exp); end
         if (k == 2) ser_en = 0;
         if (k == 5) ser_en = 1;
      end
   endtask

   task automatic test_async_reset;
      logic [W-1:0] a, b;
      logic         c;
      repeat (3) @(negedge clk);
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      ser_en = 1; in_valid = 1; in_a = a; in_b = b; in_cin = c;
      @(negedge clk);
      in_a = ~a; in_b = ~b;
      @(negedge clk);
      in_valid = 0;
      total++; if (obs !== exp_bit(a, b, c, 0)) begin bad++; $display("FAIL arst_bit0 got=%b want=%b", obs, exp_bit(a, b, c, 0)); end
      @(negedge clk);
      total++; if (obs !== exp_bit(a, b, c, 1)) begin bad++; $display("FAIL arst_bit1 got=%b want=%b", obs, exp_bit(a, b, c, 1)); end
      #2 rst = 1'b0;
      #1;
      total++; if ({obs, in_ready} !== 7'b0000001) begin bad++; $display("FAIL arst_immediate got=%b want=%b", {obs, in_ready}, 7'b0000001); end
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         total++; if ({obs, in_ready} !== 7'b0000001) begin bad++; $display("FAIL arst_quiet k=%0d got=%b want=%b", k, {obs, in_ready}, 7'b0000001); end
      end
      a = W'($urandom); b = W'($urandom); c = 1'($urandom);
      in_valid = 1; in_a = a; in_b = b; in_cin = c;
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      total++; if (obs !== exp_bit(a, b, c, 0)) begin bad++; $display("FAIL arst_new_word got=%b want=%b", obs, exp_bit(a, b, c, 0)); end
   endtask

   task automatic test_random;
      logic [5:0] q[$];
      logic [5:0] exp;
      int         accepted, started;
      logic       prev_en, draining;
      repeat (8) @(negedge clk);
      accepted = 0; started = 0; prev_en = 0;
      for (int n = 0; n < 1000; n++) begin
         draining = (n >= 800);
         if (prev_en && ser_valid && ser_first) started++;
         total++; if (in_ready !== ((accepted - started) < DEPTH)) begin bad++; $display("FAIL rand_ready n=%0d got=%b occupancy=%0d", n, in_ready, accepted - started); end
         ser_en = draining ? 1'b1 : ($urandom_range(3) != 0);
         if (ser_valid && ser_en) begin
            total++;
            if (q.size() == 0) begin bad++; $display("FAIL rand_extra_bit n=%0d got=%b want=no bit", n, obs); end
            else begin
               exp = q.pop_front();
               if (obs !== exp) begin bad++; $display("FAIL rand_bit n=%0d got=%b want=%b", n, obs, exp); end
            end
         end else if (!ser_valid) begin
            total++; if (obs !== 6'b0) begin bad++; $display("FAIL rand_idle n=%0d got=%b want=%b", n, obs, 6'b0); end
         end
         in_valid = !draining && ($urandom_range(1) == 1);
         in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
         if (in_valid && in_ready) begin
            accepted++;
            for (int i = 0; i < W; i++) q.push_back(exp_bit(in_a, in_b, in_cin, i));
         end
         prev_en = ser_en;
         @(negedge clk);
      end
      total++; if (q.size() != 0 || ser_valid !== 1'b0) begin bad++; $display("FAIL rand_drain got=%0d pending bits want=0", q.size()); end
   endtask

`ifdef SERIAL_FEEDER_STATS_EN
   task automatic test_stats;
      int pushed;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      total++; if (word_count !== 16'd0) begin bad++; $display("FAIL stats_reset got=%0d want=0", word_count); end
      pushed = 0; ser_en = 1;
      for (int n = 0; n < 80; n++) begin
         if (in_valid && in_ready) pushed++;
         in_valid = (pushed < 5);
         in_a = W'($urandom); in_b = W'($urandom); in_cin = 1'($urandom);
         @(negedge clk);
      end
      in_valid = 0;
      total++; if (word_count !== 16'd5) begin bad++; $display("FAIL stats_count got=%0d want=5", word_count); end
   endtask
`endif

   initial begin
      test_reset;
      test_single_word;
      test_back_to_back;
      test_backpressure;
      test_freeze;
      test_async_reset;
      test_random;
`ifdef SERIAL_FEEDER_STATS_EN
      test_stats;
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/serial_operand_feeder.md
Name: serial_operand_feeder

Overview:
Upstream stage of the serial adder. Accepts parallel operand pairs (a, b, carry-in) on a valid/ready handshake and buffers them in a small FIFO. Streams each pair out LSB-first, one bit of a and one bit of b per enabled cycle, with first/last framing. Inserts a programmable idle gap between words so the downstream adder can complete and reload.

Parameters:
WIDTH, 4, operand width in bits (>=2)
DEPTH, 2, FIFO depth in operand pairs (power of two, >=2)
GAP, 1, idle cycles (ser_valid low) inserted after each word's last bit (0 = back-to-back)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  upstream operand pair valid
in_ready  out  1  FIFO can accept (= not full)
in_a  in  WIDTH  operand a
in_b  in  WIDTH  operand b
in_cin  in  1  carry-in for this pair
ser_en  in  1  downstream advance enable; low freezes the serial side
ser_valid  out  1  ser_a/ser_b carry a live bit
ser_a  out  1  current bit of a
ser_b  out  1  current bit of b
ser_cin  out  1  carry-in; meaningful only while ser_first=1, else 0
ser_first  out  1  bit 0 of a word
ser_last  out  1  bit WIDTH-1 of a word

Behaviour:
- Reset (rst=0, asynchronous): FIFO empty, FSM in IDLE, bit/gap counters 0.
  - All ser_* outputs 0; in_ready=1 (combinational from FIFO count).
  - A word in flight is discarded. No output survives reset.
- Push: in_valid && in_ready at a clock edge. No push when full; no bypass.
- FIFO entry is {cin, b, a}, 2*WIDTH+1 bits. Push and pop in the same cycle is legal; count is unchanged.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: if FIFO non-empty && ser_en, pop the head into shift regs, bit_cnt=0, go to SHIFT.
  - SHIFT: ser_valid=1, ser_a=sa[0], ser_b=sb[0].
    - On each edge with ser_en=1: shift right and increment bit_cnt.
    - At bit_cnt==WIDTH-1 with ser_en=1: if GAP>0, go to GAP with gap_cnt=0.
    - Otherwise, with GAP==0: if FIFO non-empty, pop and reload (stay in SHIFT); else go to IDLE.
  - GAP: ser_valid=0. gap_cnt increments on each ser_en=1 edge. At gap_cnt==GAP-1, apply IDLE rules in the same edge (pop directly if non-empty).
- Latency: a word pushed into an empty FIFO at edge N has bit 0 visible after edge N+1 (ser_en held high).
- ser_first = SHIFT && bit_cnt==0. ser_last = SHIFT && bit_cnt==WIDTH-1.
- ser_en=0 freezes FSM, counters and shift regs; all ser_* outputs hold their values. The push side keeps operating.
- All serial outputs are registered; in_ready is combinational.

Optional Feature:
SERIAL_FEEDER_STATS_EN
- Defined: adds output word_count[15:0]. Reset 0. Increments on each edge where the last bit is consumed (ser_last && ser_en). Wraps 16'hFFFF to 0.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package serial_pkg holds:
  - the FSM state encoding (IDLE/SHIFT/GAP);
  - the default WIDTH constant shared with the serial adder;
  - the FIFO entry width function (2*WIDTH+1).
- One sub-module, serial_feeder_fifo: synchronous FIFO with parameters DEPTH and data width. It provides push/pop/full/empty and the same clk/rst.
- The FSM and shifter stay in the top module.

Test Plan:
1. WIDTH=4, GAP=1, ser_en=1; push a=4'b1011, b=4'b0110, cin=1 -> over 4 cycles ser_a=1,1,0,1 and ser_b=0,1,1,0; ser_cin=1 only on the first bit; ser_first on cycle 1, ser_last on cycle 4; then exactly 1 cycle with ser_valid=0.
2. GAP=0; push two pairs on consecutive cycles -> 8 contiguous ser_valid cycles; second word's ser_first immediately follows first word's ser_last.
3. Hold ser_en=0; push 3 pairs -> in_ready falls after 2 accepts and the third is held off. Release ser_en -> words stream in push order and in_ready returns high after the first pop.
4. Drop ser_en for 3 cycles at bit 2 of a word -> outputs hold bit 2 for those cycles, then bits 2,3 resume with no bit lost or repeated.
5. Assert rst at bit 1 of a word with 1 more pair queued -> all ser_* go 0 immediately, in_ready=1; after release nothing is emitted until a new push.
6. With SERIAL_FEEDER_STATS_EN: stream 5 words -> word_count=5; force the counter to 16'hFFFF, complete one word -> 0.
